// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package data_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LATENCY     = 3;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/dm_ram_array.sv
// Single-port word storage: synchronous write, registered read.
// The storage itself is never cleared; only the read register resets.
module dm_ram_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Commit a store on an enabled write cycle.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read; holds its value on writes and idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder between EX/MEM and MEM/WB.
// Handshake: a request (mem_read | write_enable) is taken only in IDLE;
// stall is raised combinationally in that same cycle and stays high until
// the DONE cycle, during which the pipeline holds its request inputs
// stable. The pipeline advances on the edge that leaves DONE.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             mem_read,
  input  logic             write_enable,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic             stall,
  output logic             err,
  output logic [CNT_W-1:0] access_count,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  // Counter only needs to hold LATENCY-2.
  localparam int CNT_LW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  state_t              state, state_nx;
  logic [CNT_LW-1:0]   cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-1:0]   wdata_q;
  op_t                 op_q;

  logic                req, accept, bad_req;
  logic                ram_en, ram_we;
  logic [IDX_W-1:0]    ram_idx;
  logic [WORD_W-1:0]   ram_wdata;

  assign req     = mem_read | write_enable;
  assign accept  = (state == IDLE) && req;
  // Misaligned, beyond the array (upper address bits set), or read+write.
  assign bad_req = (addr[1:0] != 2'b00) || (addr[31:2+IDX_W] != '0) ||
                   (mem_read && write_enable);

  // With LATENCY=1 the array is accessed on the capture edge itself, so it
  // must see the live inputs; otherwise it uses the holding registers.
  assign ram_en    = (LATENCY == 1) ? accept : ((state == BUSY) && (cnt == '0));
  assign ram_we    = (LATENCY == 1) ? write_enable : (op_q == OP_WRITE);
  assign ram_idx   = (LATENCY == 1) ? addr[IDX_W+1:2] : idx_q;
  assign ram_wdata = (LATENCY == 1) ? write_data : wdata_q;

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (LATENCY == 1) ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: freeze the pipeline from request until DONE.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE:    stall = req;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Capture the request and run the latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else if (accept) begin
      cnt     <= CNT_LW'((LATENCY > 1) ? (LATENCY - 2) : 0);
      idx_q   <= addr[IDX_W+1:2];
      wdata_q <= write_data;
      op_q    <= write_enable ? OP_WRITE : OP_READ;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Sticky error flag, evaluated on each captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept && bad_req) begin
      err <= 1'b1;
    end
  end

  // Saturating count of completed accesses, bumped on leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_count <= '0;
    end else if ((state == DONE) && (access_count != '1)) begin
      access_count <= access_count + 1'b1;
    end
  end

  dm_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (read_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=3/CNT_W=16 and
// LATENCY=1/CNT_W=3), a transaction-level model of memory, err, count and
// stall timing, one per-cycle compare process, plus literal pins.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic clk;
  logic rst;

  logic [31:0] addr_in [2];
  logic        rd_in   [2];
  logic        we_in   [2];
  logic [31:0] wd_in   [2];

  logic [31:0] rd_v    [2];
  logic        stall_v [2];
  logic        err_v   [2];
  logic [31:0] cnt_v   [2];
  logic [1:0]  st_v    [2];
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  assign cnt_v[0] = {16'b0, cnt0};
  assign cnt_v[1] = {29'b0, cnt1};

  // model state
  logic [31:0] mem_m     [2][DEPTH];
  logic        exp_stall [2];
  logic [31:0] exp_rd    [2];
  logic        exp_err   [2];
  logic [31:0] exp_cnt   [2];

  int          n_checks;
  int          n_pass;
  logic [7:0]  pat;
  logic [31:0] last_rd;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .addr(addr_in[0]), .mem_read(rd_in[0]),
    .write_enable(we_in[0]), .write_data(wd_in[0]), .read_data(rd_v[0]),
    .stall(stall_v[0]), .err(err_v[0]), .access_count(cnt0), .dbg_state(st_v[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .addr(addr_in[1]), .mem_read(rd_in[1]),
    .write_enable(we_in[1]), .write_data(wd_in[1]), .read_data(rd_v[1]),
    .stall(stall_v[1]), .err(err_v[1]), .access_count(cnt1), .dbg_state(st_v[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int s);
    return (s == 0) ? 3 : 1;
  endfunction

  function automatic logic [31:0] cap(input int s);
    return (s == 0) ? 32'd65535 : 32'd7;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs(input int s);
    rd_in[s]   = 1'b0;
    we_in[s]   = 1'b0;
    addr_in[s] = '0;
    wd_in[s]   = '0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_stall[s] = 1'b0;
      exp_rd[s]    = '0;
      exp_err[s]   = 1'b0;
      exp_cnt[s]   = '0;
    end
  endtask

  // driver: one full access, held until the pipeline is released
  task automatic access(input int s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned ix;
    bit          bad;
    ix  = (a >> 2) % DEPTH;
    bad = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH) || (rd && wr);
    rd_in[s] = rd; we_in[s] = wr; addr_in[s] = a; wd_in[s] = d;
    exp_stall[s] = 1'b1;
    #1 pat = {pat[6:0], stall_v[s]};
    for (int k = 1; k <= lat(s); k++) begin
      step();
      if (k == 1) exp_err[s] = exp_err[s] | bad;
      if (k == lat(s)) begin
        exp_stall[s] = 1'b0;
        if (wr) mem_m[s][ix] = d;
        else    exp_rd[s] = mem_m[s][ix];
      end
      #1 pat = {pat[6:0], stall_v[s]};
    end
    last_rd = rd_v[s];
    step();
    if (exp_cnt[s] < cap(s)) exp_cnt[s] = exp_cnt[s] + 1;
    clear_inputs(s);
  endtask

  // scoreboard compare, every cycle, both instances
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      check($sformatf("stall[%0d]", s), {31'b0, stall_v[s]}, {31'b0, exp_stall[s]});
      check($sformatf("read_data[%0d]", s), rd_v[s], exp_rd[s]);
      check($sformatf("err[%0d]", s), {31'b0, err_v[s]}, {31'b0, exp_err[s]});
      check($sformatf("access_count[%0d]", s), cnt_v[s], exp_cnt[s]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pat      = '0;
    last_rd  = '0;
    rst      = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    model_reset();
    step();
    step();
    check("reset_state0", {30'b0, st_v[0]}, 32'd0);
    check("reset_cnt0", cnt_v[0], 32'd0);
    rst = 1'b1;
    step();

    // LATENCY=3: write then read back
    pat = '0;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("wr_stall_pattern", {28'b0, pat[3:0]}, 32'b1110);
    check("wr_count", cnt_v[0], 32'd1);
    check("wr_err", {31'b0, err_v[0]}, 32'd0);
    pat = '0;
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("rd_data", last_rd, 32'hDEADBEEF);
    check("rd_stall_pattern", {28'b0, pat[3:0]}, 32'b1110);

    // LATENCY=1: back-to-back write/read
    pat = '0;
    access(1, 1'b0, 1'b1, 32'h4, 32'h55);
    access(1, 1'b1, 1'b0, 32'h4, 32'h0);
    check("l1_stall_pattern", {28'b0, pat[3:0]}, 32'b1010);
    check("l1_rd_data", last_rd, 32'h55);
    check("l1_err_clean", {31'b0, err_v[1]}, 32'd0);

    // misaligned read of word 4
    access(0, 1'b0, 1'b1, 32'h10, 32'h1234);
    access(0, 1'b1, 1'b0, 32'h12, 32'h0);
    check("misaligned_rd", last_rd, 32'h1234);
    check("misaligned_err", {31'b0, err_v[0]}, 32'd1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("err_sticky", {31'b0, err_v[0]}, 32'd1);

    // read+write conflict: write wins
    access(0, 1'b1, 1'b1, 32'h20, 32'h7);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0);
    check("conflict_rd", last_rd, 32'h7);

    // out-of-range address wraps onto word 4 (LATENCY=1 instance)
    access(1, 1'b0, 1'b1, 32'h1010, 32'h99);
    check("oob_err", {31'b0, err_v[1]}, 32'd1);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0);
    check("oob_wrap_rd", last_rd, 32'h99);

    // counter saturation on the 3-bit instance
    for (int i = 0; i < 6; i++) begin
      access(1, i[0], !i[0], 32'h40, 32'h100 + i);
    end
    check("cnt_saturated", cnt_v[1], 32'd7);
    check("sat_rd", last_rd, 32'h104);

    // reset during the second BUSY cycle of a write
    access(0, 1'b0, 1'b1, 32'h8, 32'h0);
    rd_in[0] = 1'b0; we_in[0] = 1'b1; addr_in[0] = 32'h8; wd_in[0] = 32'hAA;
    exp_stall[0] = 1'b1;
    step();
    step();
    check("busy2_state", {30'b0, st_v[0]}, 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_stall", {31'b0, stall_v[0]}, 32'd0);
    check("rst_state", {30'b0, st_v[0]}, 32'd0);
    check("rst_count", cnt_v[0], 32'd0);
    clear_inputs(0);
    step();
    step();
    rst = 1'b1;
    step();
    access(0, 1'b1, 1'b0, 32'h8, 32'h0);
    check("rst_discard_rd", last_rd, 32'h0);
    check("post_rst_count", cnt_v[0], 32'd1);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle responder for the pipeline's data-memory port: it takes the EX/MEM-stage request (address, mem_read, write_enable, write_data) and answers after a fixed latency.
- It holds `stall` high until the access completes, so the pipeline freezes PC, IF/ID, ID/EX and EX/MEM while the access is pending.
- It replaces the zero-wait combinational data memory. It sits between the EX/MEM register and the MEM/WB register.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; must be a power of 2.
- LATENCY, 3: cycles from request acceptance to completion; must be ≥ 1.
- CNT_W, 16: width of the access counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from EX/MEM ALU result.
- mem_read  in  1  read request.
- write_enable  in  1  write request.
- write_data  in  32  store data from EX/MEM.
- read_data  out  32  load result; valid in the DONE cycle, held otherwise.
- stall  out  1  pipeline freeze request.
- err  out  1  sticky: misaligned, out-of-range, or read+write conflict seen.
- access_count  out  CNT_W  completed accesses; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; stall=0, read_data=0, err=0, access_count=0.
  - Any pending access is discarded and its write is never committed.
  - The storage array is not cleared.
- Request definition: req = mem_read | write_enable, sampled in IDLE only.
- IDLE:
  - stall = req, combinationally in the same cycle.
  - On a clock edge with req=1:
    - capture addr, write_data and op into holding registers;
    - op=WRITE if write_enable=1, else READ;
    - go to DONE if LATENCY=1, else go to BUSY with cnt=LATENCY-2.
  - With req=0: stay in IDLE, no state change.
- BUSY:
  - stall=1.
  - If cnt==0 go to DONE, else cnt decrements.
  - Request inputs are ignored; they are held stable by the frozen pipeline.
- DONE:
  - stall=0.
  - READ: read_data = mem[idx] (registered on DONE entry).
  - WRITE: mem[idx] is written on the DONE-entry edge; read_data keeps its previous value.
  - access_count increments (saturating) on exit from DONE.
  - Next state is always IDLE. The pipeline advances on this edge, so the following IDLE cycle sees the next instruction's request.
- Latency: stall is high for exactly LATENCY cycles per access. A back-to-back access costs LATENCY+1 cycles including the DONE cycle.
- Index: idx = addr[2+log2(DEPTH_WORDS)-1 : 2]; addresses wrap modulo DEPTH_WORDS.
- err is set on a captured request if any of these hold:
  - addr[1:0] ≠ 0 (the access proceeds word-aligned, low bits ignored);
  - addr[31:2] ≥ DEPTH_WORDS (the access wraps);
  - mem_read=1 and write_enable=1 together (WRITE wins).
- err clears only on reset.
- Read-after-write to the same word in consecutive accesses returns the new data; there is no bypass, because the write commits before the next capture.
- No request is accepted outside IDLE.

Decomposition:
- Package data_mem_pkg holds:
  - typedef enum state_t {IDLE, BUSY, DONE};
  - typedef enum op_t {OP_READ, OP_WRITE};
  - WORD_W=32 and localparam default values.
- One sub-module, dm_ram_array: synchronous single-port storage with write enable and a registered read, taking an index and DEPTH_WORDS.
- The FSM, latency counter, error logic and access counter stay in data_mem_responder.

Test Plan:
- Reset, then write_enable=1, addr=0x10, write_data=0xDEADBEEF, LATENCY=3:
  - stall=1 for 3 cycles, then 0 for one cycle;
  - access_count=1, err=0.
- Next, mem_read=1, addr=0x10:
  - read_data=0xDEADBEEF in the DONE cycle;
  - stall pattern 1,1,1,0.
- LATENCY=1, back-to-back write 0x55 to addr 0x4, then read addr 0x4:
  - stall pattern 1,0,1,0;
  - read_data=0x55.
- Read addr=0x12 with mem[4]=0x1234:
  - read_data=0x1234;
  - err=1 and stays 1 after later clean accesses.
- mem_read=1 and write_enable=1 together, addr=0x20, data=0x7:
  - the write happens, err=1;
  - a subsequent read of 0x20 returns 0x7.
- Assert rst=0 in the 2nd BUSY cycle of a write of 0xAA to addr 0x8 (prior contents 0x0):
  - stall drops immediately, state=IDLE, access_count=0;
  - a read of 0x8 after reset returns 0x0.
